// File: rtl/sr_ff_checker.sv
// rtl/sr_ff_checker.sv - self-checking monitor for the sr_ff set/reset flip-flop
//
// Tracks a cycle-accurate reference model of sr_ff from the same s/r
// stimulus and compares the flip-flop's q/q_bar against it on every enabled
// edge where the model state is known.
//
// Parameters:
//   CNT_W          width of every counter and of first_err_idx
// Ports:
//   clk            rising-edge clock shared with the observed sr_ff
//   rst            asynchronous active-high reset
//   en             check enable; gates comparisons and all counting
//   clr            synchronous clear of counters and flags (not the model)
//   s, r           set/reset requests tapped from the flip-flop inputs
//   q, q_bar       flip-flop outputs under test
//   err            one-cycle pulse per mismatching edge
//   err_sticky     set on the first mismatch, held until clr/rst
//   err_cnt        saturating count of mismatches
//   chk_cnt        saturating count of comparisons performed
//   illegal_cnt    saturating count of enabled s=r=1 requests
//   first_err_idx  chk_cnt value at the first mismatch
//   model_valid    reference model state is known
module sr_ff_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             s,
   input  logic             r,
   input  logic             q,
   input  logic             q_bar,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             model_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic m_q;
   logic do_chk;
   logic mismatch;
   logic illegal;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // The comparison uses the model state produced by the previous edge and
   // the q/q_bar settled after that edge, so a correct one-cycle flip-flop
   // matches with zero slack.
   always_comb begin
      do_chk   = en & model_valid;
      mismatch = (q != m_q) | (q_bar != ~m_q);
      illegal  = en & s & r;
   end

   // Reference model: runs regardless of en and is untouched by clr so that
   // re-enabling or clearing never needs a resync.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q         <= 1'b0;
         model_valid <= 1'b1;
      end else begin
         case ({s, r})
            2'b10:   begin m_q <= 1'b1; model_valid <= 1'b1; end
            2'b01:   begin m_q <= 1'b0; model_valid <= 1'b1; end
            2'b11:   model_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Checker state: clr overrides every increment, capture and pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err           <= 1'b0;
         err_sticky    <= 1'b0;
         err_cnt       <= '0;
         chk_cnt       <= '0;
         illegal_cnt   <= '0;
         first_err_idx <= '0;
      end else if (clr) begin
         err           <= 1'b0;
         err_sticky    <= 1'b0;
         err_cnt       <= '0;
         chk_cnt       <= '0;
         illegal_cnt   <= '0;
         first_err_idx <= '0;
      end else begin
         err <= do_chk & mismatch;
         if (do_chk) begin
            chk_cnt <= sat_inc(chk_cnt);
         end
         if (do_chk && mismatch) begin
            err_cnt    <= sat_inc(err_cnt);
            err_sticky <= 1'b1;
            // Pre-increment (possibly already saturated) check index.
            if (!err_sticky) begin
               first_err_idx <= chk_cnt;
            end
         end
         if (illegal) begin
            illegal_cnt <= sat_inc(illegal_cnt);
         end
      end
   end

endmodule

// File: tb/tb_sr_ff_checker.sv
// tb/tb_sr_ff_checker.sv - table-driven scoreboard bench for sr_ff_checker
module tb_sr_ff_checker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic clr = 1'b0;
   logic s = 1'b0;
   logic r = 1'b0;
   logic stuck = 1'b0;
   logic ff_q;
   logic q, q_bar;
   logic err, err_sticky, model_valid;
   logic [7:0] err_cnt, chk_cnt, illegal_cnt, first_err_idx;

   logic en2 = 1'b0;
   logic q2 = 1'b0;
   logic qb2 = 1'b1;
   logic err2, err_sticky2, model_valid2;
   logic [1:0] err_cnt2, chk_cnt2, illegal_cnt2, first_err_idx2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Behavioural sr_ff driving the checker, with an optional q stuck-at-0 fault.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            ff_q <= 1'b0;
      else if (s && !r)   ff_q <= 1'b1;
      else if (r && !s)   ff_q <= 1'b0;
   end
   assign q     = stuck ? 1'b0 : ff_q;
   assign q_bar = ~ff_q;

   sr_ff_checker #(.CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r),
      .q(q), .q_bar(q_bar), .err(err), .err_sticky(err_sticky),
      .err_cnt(err_cnt), .chk_cnt(chk_cnt), .illegal_cnt(illegal_cnt),
      .first_err_idx(first_err_idx), .model_valid(model_valid)
   );

   sr_ff_checker #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .en(en2), .clr(1'b0), .s(s), .r(r),
      .q(q2), .q_bar(qb2), .err(err2), .err_sticky(err_sticky2),
      .err_cnt(err_cnt2), .chk_cnt(chk_cnt2), .illegal_cnt(illegal_cnt2),
      .first_err_idx(first_err_idx2), .model_valid(model_valid2)
   );

   typedef struct {
      logic rst_b, s, r, en, clr, stuck;
      logic e_err, e_st;
      int   e_ec, e_cc, e_ill, e_idx;
      logic e_mv;
   } vec_t;

   typedef struct {
      logic e_err, e_st;
      int   e_ec, e_cc, e_ill, e_idx;
      logic e_mv;
   } exp_t;

   vec_t vecs[23];
   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic compare_main(input string tag, input exp_t e);
      check({tag, " err"},           int'(err),           int'(e.e_err));
      check({tag, " err_sticky"},    int'(err_sticky),    int'(e.e_st));
      check({tag, " err_cnt"},       int'(err_cnt),       e.e_ec);
      check({tag, " chk_cnt"},       int'(chk_cnt),       e.e_cc);
      check({tag, " illegal_cnt"},   int'(illegal_cnt),   e.e_ill);
      check({tag, " first_err_idx"}, int'(first_err_idx), e.e_idx);
      check({tag, " model_valid"},   int'(model_valid),   int'(e.e_mv));
   endtask

   task automatic do_reset();
      @(negedge clk);
      s = 0; r = 0; en = 0; clr = 0;
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      exp_t e;
      exp_t rv;
      rv = '{1'b0, 1'b0, 0, 0, 0, 0, 1'b1};

      //          rst s  r  en clr stk | err st ec cc ill idx mv
      // basic sequence and illegal request
      vecs[0]  = '{1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 1};
      vecs[1]  = '{0, 1, 0, 1, 0, 0,  0, 0, 0, 2, 0, 0, 1};
      vecs[2]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 3, 0, 0, 1};
      vecs[3]  = '{0, 0, 1, 1, 0, 0,  0, 0, 0, 4, 0, 0, 1};
      vecs[4]  = '{0, 1, 1, 1, 0, 0,  0, 0, 0, 5, 1, 0, 0};
      vecs[5]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 5, 1, 0, 0};
      vecs[6]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 5, 1, 0, 0};
      vecs[7]  = '{0, 1, 0, 1, 0, 0,  0, 0, 0, 5, 1, 0, 1};
      vecs[8]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 6, 1, 0, 1};
      // q stuck at 0, set at the third checked edge
      vecs[9]  = '{1, 0, 0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 1};
      vecs[10] = '{0, 0, 0, 1, 0, 1,  0, 0, 0, 2, 0, 0, 1};
      vecs[11] = '{0, 1, 0, 1, 0, 1,  0, 0, 0, 3, 0, 0, 1};
      vecs[12] = '{0, 0, 0, 1, 0, 1,  1, 1, 1, 4, 0, 3, 1};
      vecs[13] = '{0, 0, 0, 1, 0, 1,  1, 1, 2, 5, 0, 3, 1};
      vecs[14] = '{0, 0, 1, 1, 0, 1,  1, 1, 3, 6, 0, 3, 1};
      vecs[15] = '{0, 0, 0, 1, 0, 1,  0, 1, 3, 7, 0, 3, 1};
      vecs[16] = '{0, 1, 0, 1, 0, 1,  0, 1, 3, 8, 0, 3, 1};
      // clr together with a mismatch; model keeps m_q=1
      vecs[17] = '{0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 1};
      vecs[18] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 1};
      // en=0: mismatch and illegal request ignored, model still tracks
      vecs[19] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 1};
      vecs[20] = '{0, 1, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0};
      vecs[21] = '{0, 0, 1, 1, 0, 1,  0, 0, 0, 1, 0, 0, 1};
      vecs[22] = '{0, 0, 0, 1, 0, 1,  0, 0, 0, 2, 0, 0, 1};

      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      compare_main("reset", rv);
      @(negedge clk);
      rst = 0;

      // CNT_W=2 instance: six consecutive mismatches from reset
      en2 = 1; q2 = 1; qb2 = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("sat%0d err", k),      int'(err2),           1);
         check($sformatf("sat%0d err_cnt", k),  int'(err_cnt2),       (k < 3) ? k : 3);
         check($sformatf("sat%0d chk_cnt", k),  int'(chk_cnt2),       (k < 3) ? k : 3);
         check($sformatf("sat%0d first_idx", k), int'(first_err_idx2), 0);
      end
      check("sat sticky", int'(err_sticky2), 1);
      @(negedge clk);
      en2 = 0; q2 = 0; qb2 = 1;

      for (int i = 0; i < 23; i++) begin
         if (vecs[i].rst_b) do_reset();
         else @(negedge clk);
         s = vecs[i].s; r = vecs[i].r; en = vecs[i].en;
         clr = vecs[i].clr; stuck = vecs[i].stuck;
         sb.push_back('{vecs[i].e_err, vecs[i].e_st, vecs[i].e_ec, vecs[i].e_cc,
                        vecs[i].e_ill, vecs[i].e_idx, vecs[i].e_mv});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         compare_main($sformatf("vec%0d", i), e);
      end

      // Asynchronous reset mid-run after two mismatches
      do_reset();
      stuck = 1; en = 1; s = 1; r = 0;
      @(negedge clk);
      s = 0;
      repeat (2) @(negedge clk);
      check("pre-rst err_cnt", int'(err_cnt), 2);
      check("pre-rst err",     int'(err),     1);
      rst = 1;
      #1;
      compare_main("async rst", rv);
      @(posedge clk);
      @(negedge clk);
      rst = 0; stuck = 0; en = 0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sr_ff_checker.md
# sr_ff_checker

Synthesizable self-checking monitor for the `sr_ff` set/reset flip-flop. It observes the same `s`/`r` stimulus the flip-flop receives, keeps a cycle-accurate reference model, and compares the flip-flop's `q`/`q_bar` against that model. It reports mismatches, illegal `s=r=1` requests and check coverage through saturating counters and flags, so on-chip or FPGA bring-up of `sr_ff` can run without a simulator.

## Interface

- `CNT_W`, default 8: width of every counter and of `first_err_idx`.

- `clk`  in  1  system clock, rising edge; the same clock as the observed `sr_ff`.
- `rst`  in  1  asynchronous, active-high reset. It is asserted together with the observed flip-flop's reset; the top level handles polarity.
- `en`  in  1  check enable; gates comparisons and all counting.
- `clr`  in  1  synchronous clear of counters and flags.
- `s`  in  1  set request, tapped from the flip-flop input.
- `r`  in  1  reset request, tapped from the flip-flop input.
- `q`  in  1  flip-flop output under test.
- `q_bar`  in  1  complementary output under test.
- `err`  out  1  one-cycle pulse flagging a mismatch.
- `err_sticky`  out  1  set on the first mismatch; held until `clr` or `rst`.
- `err_cnt`  out  CNT_W  count of mismatches.
- `chk_cnt`  out  CNT_W  count of comparisons performed.
- `illegal_cnt`  out  CNT_W  count of `s=r=1` requests.
- `first_err_idx`  out  CNT_W  value of `chk_cnt` at the first mismatch.
- `model_valid`  out  1  reference model state is known.

## Operation

Reference model:
- State is held in register `m_q` plus `model_valid`.
- The model updates on every rising edge, regardless of `en`:
  - `s=1`, `r=0`: `m_q` becomes 1 and `model_valid` becomes 1.
  - `s=0`, `r=1`: `m_q` becomes 0 and `model_valid` becomes 1.
  - `s=0`, `r=0`: state holds.
  - `s=1`, `r=1`: `model_valid` becomes 0 and `m_q` holds. The model stays invalid until the next `10` or `01` request.

Comparison, performed at each edge where `en=1` and `model_valid=1`:
- A mismatch is `q != m_q` or `q_bar != ~m_q`.
- A `q_bar` that is not the complement of `q` therefore always counts as a mismatch.
- `chk_cnt` increments by 1 per comparison.
- On a mismatch:
  - `err_cnt` increments by 1.
  - `err` pulses.
  - `err_sticky` is set.
  - If `err_sticky` was 0, `first_err_idx` captures the pre-increment `chk_cnt`.
- `illegal_cnt` increments at each edge with `en=1` and `s=r=1`.

Counter rules:
- All counters saturate at 2^CNT_W−1 and never wrap.
- `first_err_idx` captures the saturated value if saturation has already occurred.

Clear:
- `clr=1` zeroes all counters, `err_sticky`, `first_err_idx` and `err`.
- `clr` does not touch the model state.
- `clr` wins over any increment, capture or pulse in the same cycle.

## Timing

- Reset values: `m_q=0`, `model_valid=1`, `err=0`, `err_sticky=0`, and all counters and `first_err_idx` = 0. This matches the flip-flop's reset output `q=0`, `q_bar=1`.
- Reset asserted mid-operation clears everything immediately (asynchronous). Checking resumes on the first edge after `rst` deasserts.
- Comparison at edge k uses:
  - `q`/`q_bar` as settled after edge k−1;
  - the model state produced by edge k−1 from the `s`/`r` sampled there.
  - This gives zero-slack prediction of a one-cycle flip-flop.
- Outputs are registered. `err` and all counter updates become visible in the cycle after edge k and are never combinational from the inputs.
- `err` is high for exactly one cycle per mismatching edge. Back-to-back mismatches hold `err` high continuously.
- `en=0`: no comparisons, no counting, and `err` stays 0. The model keeps tracking, so re-enabling needs no resync.

## Test plan

- Reset, then apply `s/r` = 00, 10, 00, 01 for one cycle each with a correct flip-flop, `en=1`. Required: `chk_cnt=4`, `err_cnt=0`, `err_sticky=0`, `model_valid=1`.
- Apply `s/r` = 11 for one cycle, then 00 for two cycles. Required: `illegal_cnt=1`, `model_valid=0`, `chk_cnt` frozen for those cycles. Then apply 10. Required: `model_valid=1` on the next cycle and checking resumes.
- Inject a fault with `q` stuck at 0, then apply `s=1`, `r=0` at the 3rd checked edge. Required:
  - `err` pulses one cycle at the following check;
  - `err_cnt=1`, `err_sticky=1`, `first_err_idx=3`;
  - later mismatches increase `err_cnt` but leave `first_err_idx=3`.
- Set `CNT_W=2` and force 6 consecutive mismatches. Required: `err_cnt=3` and `chk_cnt=3`, both saturated; `first_err_idx=0`.
- Assert `clr` in the same cycle as a mismatch. Required: counters and `err_sticky` are 0 and `err` stays 0 on the next cycle; `model_valid` and `m_q` are unchanged.
- Assert `rst` mid-run after `err_cnt=2`. Required: all outputs return to reset values immediately, without waiting for a clock edge.
